// File: rtl/cond_qualifier_pkg.sv
// Shared types and constants for the condition qualifier.
package cond_qualifier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    REQ  = 2'd2,
    ACKD = 2'd3
  } state_t;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_OR  = 1;

endpackage

// File: rtl/cond_reduce.sv
// Masked AND/OR reduction of the registered condition inputs.
module cond_reduce
  import cond_qualifier_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned OP_MODE = OP_AND
) (
  input  logic [N_IN-1:0] din_q,
  input  logic [N_IN-1:0] mask_q,
  output logic            raw
);

  generate
    if (OP_MODE == OP_OR) begin : g_or
      always_comb raw = |(din_q & ~mask_q);
    end else begin : g_and
      // Masked bits read as 1 for the AND; a fully masked vector must still yield 0.
      always_comb raw = (&(din_q | mask_q)) & ~(&mask_q);
    end
  endgenerate

endmodule

// File: rtl/cond_qualifier.sv
// Qualifies a masked condition for STABLE_CYC cycles, then runs a req/ack handshake.
module cond_qualifier
  import cond_qualifier_pkg::*;
#(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned OP_MODE    = OP_AND,
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_IN-1:0] din,
  input  logic [N_IN-1:0] mask,
  input  logic            ack,
  output logic            dout,
  output logic            req,
  output logic            busy,
  output logic [7:0]      abort_cnt
);

  localparam int unsigned    CW   = $clog2(STABLE_CYC + 1);
  // Terminal count compared against cnt, equivalent to cnt+1 == STABLE_CYC.
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CYC - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_IN-1:0] din_q, mask_q;
  logic            raw;
  logic            abort_inc;

  cond_reduce #(
    .N_IN    (N_IN),
    .OP_MODE (OP_MODE)
  ) u_reduce (
    .din_q  (din_q),
    .mask_q (mask_q),
    .raw    (raw)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    abort_inc = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (raw) begin
            if (STABLE_CYC == 1) begin
              state_n = REQ;
              cnt_n   = '0;
            end else begin
              state_n = QUAL;
              cnt_n   = CW'(1);
            end
          end
        end
        QUAL: begin
          if (!raw) begin
            state_n   = IDLE;
            cnt_n     = '0;
            abort_inc = 1'b1;
          end else if (cnt == LAST) begin
            state_n = REQ;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        REQ: begin
          // An ack coinciding with a dropped condition is honoured, not counted as an abort.
          if (ack) begin
            state_n = raw ? ACKD : IDLE;
          end else if (!raw) begin
            state_n   = IDLE;
            abort_inc = 1'b1;
          end
        end
        ACKD: begin
          if (!raw) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      din_q     <= '0;
      mask_q    <= '1;
      abort_cnt <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      din_q  <= din;
      mask_q <= mask;
      if (abort_inc && (abort_cnt != '1)) abort_cnt <= abort_cnt + 8'd1;
    end
  end

  always_comb begin
    dout = (state == REQ) || (state == ACKD);
    req  = (state == REQ);
    busy = (state != IDLE);
  end

endmodule

// File: doc/cond_qualifier.md
COND_QUALIFIER -- requirements
Module: cond_qualifier

Interface
REQ-001 Parameter N_IN, default 4, number of condition inputs; legal range 1..32.
REQ-002 Parameter OP_MODE, default 0, reduction operator: 0 = AND of unmasked inputs, 1 = OR of unmasked inputs.
REQ-003 Parameter STABLE_CYC, default 2, consecutive true cycles required before qualifying; legal range 1..255.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  block enable; low forces IDLE.
REQ-007 din  input  N_IN  condition inputs, e.g. bus grant, device ready, count nonzero.
REQ-008 mask  input  N_IN  1 = input ignored, 0 = input participates.
REQ-009 ack  input  1  consumer acknowledge of req.
REQ-010 dout  output  1  qualified condition level.
REQ-011 req  output  1  request to consumer, held until ack or withdrawal.
REQ-012 busy  output  1  high in QUAL, REQ and ACKD.
REQ-013 abort_cnt  output  8  saturating count of qualification aborts.

Function
REQ-014 din and mask SHALL be registered once (din_q, mask_q) before use; raw is computed combinationally from din_q and mask_q.
REQ-015 raw SHALL be the OP_MODE reduction over the unmasked bits; when all bits are masked, raw SHALL be 0 in both modes.
REQ-016 The FSM SHALL have states IDLE, QUAL, REQ and ACKD, with Moore outputs: dout=1 in REQ and ACKD; req=1 in REQ only.
REQ-017 IDLE: raw=1 SHALL go to REQ if STABLE_CYC=1; otherwise it SHALL go to QUAL with cnt=1.
REQ-018 QUAL: raw=1 SHALL increment cnt, moving to REQ when cnt+1=STABLE_CYC; raw=0 SHALL go to IDLE, clear cnt and increment abort_cnt.
REQ-019 REQ: ack=1 SHALL go to ACKD; raw=0 with ack=0 SHALL go to IDLE (req withdrawn) and increment abort_cnt.
REQ-020 REQ with ack=1 and raw=0 in the same cycle SHALL go to IDLE; the ack is honoured and no abort is counted.
REQ-021 ACKD: raw=0 SHALL go to IDLE; ack SHALL be ignored.
REQ-022 ack SHALL be ignored in IDLE, QUAL and ACKD.
REQ-023 en=0 SHALL force IDLE and clear cnt on the next edge from any state, with priority over all other conditions; no abort is counted.
REQ-024 Latency: with din stable true before capture edge E0, dout and req SHALL rise after edge E0+STABLE_CYC.
REQ-025 cnt width SHALL be $clog2(STABLE_CYC+1).
REQ-026 abort_cnt SHALL saturate at 255 and never wrap.
REQ-027 A mask change SHALL take effect one cycle later, via mask_q, like any din change.

Reset
REQ-028 rst_n low SHALL asynchronously force the state to IDLE and set cnt=0, din_q=0, mask_q=all-ones, abort_cnt=0, dout=0, req=0 and busy=0.
REQ-029 Reset asserted mid-handshake (REQ or ACKD) SHALL drop req and dout immediately, without waiting for a clock edge.
REQ-030 Release of rst_n SHALL be sampled synchronously; the first active edge evaluates from IDLE.

Structure
REQ-031 Shared package cond_qualifier_pkg SHALL hold the state enum (IDLE, QUAL, REQ, ACKD) and the OP_AND=0 and OP_OR=1 constants.
REQ-032 One combinational sub-module, cond_reduce (parameters N_IN and OP_MODE; ports din_q, mask_q, raw), SHALL implement REQ-015; the FSM, counters and registers SHALL live in cond_qualifier.

Verification
REQ-033 N_IN=4, OP_MODE=0, STABLE_CYC=2, mask=0000, din=1111 held -> dout=req=1 after 3rd edge; ack pulse -> req=0, dout=1; din=1110 -> dout=0 two edges later.
REQ-034 Same config, din=1111 for 1 cycle then 1110 -> state QUAL then IDLE, dout never high, abort_cnt=1.
REQ-035 OP_MODE=1, mask=1110, din=0001 -> dout=1 after 3 edges; mask=1111 -> raw=0, return to IDLE, abort_cnt unchanged if already ACKD.
REQ-036 In REQ, ack=1 and din=0000 in the same cycle -> IDLE, abort_cnt unchanged; en=0 in QUAL -> IDLE next edge, no abort counted.
REQ-037 Force 300 aborts -> abort_cnt=255; rst_n low while in REQ -> req=0 before the next clk edge, abort_cnt=0.
REQ-038 STABLE_CYC=1, din true -> dout high after 2nd edge; STABLE_CYC=255 -> dout high after edge 256, none earlier.
